// File: rtl/padd_pkg.sv
// Shared definitions for the pipelined parallel adder: operation encoding and sizing helpers.
package padd_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_ACC = 2'd2,
        MODE_CLR = 2'd3
    } padd_mode_e;

    localparam logic [1:0] PADD_MODE_ADD = 2'd0;
    localparam logic [1:0] PADD_MODE_SUB = 2'd1;
    localparam logic [1:0] PADD_MODE_ACC = 2'd2;
    localparam logic [1:0] PADD_MODE_CLR = 2'd3;

    // The epoch counter must be able to hold MAX_COUNT itself.
    function automatic int count_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/padd_if.sv
// Operand/result handshake bundle for tt_um_parallel_adder_pipe; master drives operands, slave is the adder.
interface padd_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             epoch_wrap;

    modport master (
        output in_valid, a, b, cin, mode, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, epoch_wrap
    );

    modport slave (
        input  in_valid, a, b, cin, mode, out_ready,
        output in_ready, out_valid, sum, cout, ovf, epoch_wrap
    );

endinterface

// File: rtl/padd_ripple.sv
// Combinational ripple-carry chain of full adders; the only arithmetic in the adder pipe.
module padd_ripple #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/tt_um_parallel_adder_pipe.sv
// One-stage pipelined ADD/SUB/ACC/CLR unit with an epoch counter that auto-clears the accumulator.
// Define PADD_SAT_EN to build the saturating variant (ovf output becomes live).
module tt_um_parallel_adder_pipe
    import padd_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 1000
) (
    input logic    clk,
    input logic    rst,
    padd_if.slave  bus
);

    localparam int CW = count_width(MAX_COUNT);
    localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_COUNT - 1);

    padd_mode_e       mode_e;
    logic             accept;
    logic             epoch_last;

    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             op_c;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic [WIDTH-1:0] res_sum;
    logic             res_cout;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             wrap_q;

    assign mode_e       = padd_mode_e'(bus.mode);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign epoch_last   = (cnt == LAST_COUNT);

    // One shared adder: SUB feeds ~b with carry 1, ACC feeds the accumulator in place of a.
    always_comb begin
        op_x = bus.a;
        op_y = bus.b;
        op_c = bus.cin;
        case (mode_e)
            MODE_SUB: begin
                op_y = ~bus.b;
                op_c = 1'b1;
            end
            MODE_ACC: begin
                op_x = acc;
                op_y = bus.a;
            end
            default: ;
        endcase
    end

    padd_ripple #(
        .WIDTH (WIDTH)
    ) u_ripple (
        .a    (op_x),
        .b    (op_y),
        .cin  (op_c),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef PADD_SAT_EN
    logic res_ovf;
    logic ovf_q;

    // Carry out of ADD/ACC pins to all-ones; a borrow on SUB clamps to zero. cout stays raw.
    always_comb begin
        res_sum  = add_sum;
        res_cout = add_cout;
        res_ovf  = 1'b0;
        if ((mode_e == MODE_ADD || mode_e == MODE_ACC) && add_cout) begin
            res_sum = '1;
            res_ovf = 1'b1;
        end else if (mode_e == MODE_SUB && !add_cout) begin
            res_sum = '0;
            res_ovf = 1'b1;
        end
        if (mode_e == MODE_CLR) begin
            res_sum  = '0;
            res_cout = 1'b0;
            res_ovf  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= res_ovf;
        end
    end

    assign bus.ovf = ovf_q;
`else
    always_comb begin
        res_sum  = add_sum;
        res_cout = add_cout;
        if (mode_e == MODE_CLR) begin
            res_sum  = '0;
            res_cout = 1'b0;
        end
    end

    assign bus.ovf = 1'b0;
`endif

    // Result register, accumulator and epoch counter only move on accept; out_valid also drains.
    // An epoch wrap clears acc even on an ACC beat, but that beat's result is still delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            wrap_q      <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (accept) begin
                out_valid_q <= 1'b1;
                sum_q       <= res_sum;
                cout_q      <= res_cout;
                wrap_q      <= epoch_last;
                cnt         <= epoch_last ? '0 : cnt + CW'(1);
                if (epoch_last || mode_e == MODE_CLR) begin
                    acc <= '0;
                end else if (mode_e == MODE_ACC) begin
                    acc <= res_sum;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.sum        = sum_q;
    assign bus.cout       = cout_q;
    assign bus.epoch_wrap = wrap_q;

endmodule

// File: tb/tb_tt_um_parallel_adder_pipe.sv
// Scoreboard bench for tt_um_parallel_adder_pipe (WIDTH=8, MAX_COUNT=4); honours PADD_SAT_EN.
module tb_tt_um_parallel_adder_pipe;

    localparam int WIDTH     = 8;
    localparam int MAX_COUNT = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             wrap;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    exp_t             sb[$];
    exp_t             e;
    logic [WIDTH-1:0] acc_m;
    int               cnt_m;

    padd_if #(.WIDTH(WIDTH)) bus ();

    tt_um_parallel_adder_pipe #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [WIDTH+3:0] obs = {bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.epoch_wrap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour of one accepted beat, pushed in acceptance order.
    task automatic model_push(input logic [1:0] m, input logic [WIDTH-1:0] x,
                              input logic [WIDTH-1:0] y, input logic c);
        logic [WIDTH:0] r;
        exp_t           ex;
        case (m)
            2'd0:    r = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
            2'd1:    r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
            2'd2:    r = {1'b0, acc_m} + {1'b0, x} + (WIDTH+1)'(c);
            default: r = '0;
        endcase
        ex.sum  = r[WIDTH-1:0];
        ex.cout = r[WIDTH];
        ex.ovf  = 1'b0;
`ifdef PADD_SAT_EN
        if ((m == 2'd0 || m == 2'd2) && r[WIDTH]) begin
            ex.sum = '1;
            ex.ovf = 1'b1;
        end else if (m == 2'd1 && !r[WIDTH]) begin
            ex.sum = '0;
            ex.ovf = 1'b1;
        end
`endif
        cnt_m = cnt_m + 1;
        ex.wrap = (cnt_m == MAX_COUNT);
        if (ex.wrap) begin
            cnt_m = 0;
            acc_m = '0;
        end else if (m == 2'd3) begin
            acc_m = '0;
        end else if (m == 2'd2) begin
            acc_m = ex.sum;
        end
        sb.push_back(ex);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        acc_m = '0;
        cnt_m = 0;
        sb.delete();
    endtask

    task automatic drive_beat(input logic [1:0] m, input logic [WIDTH-1:0] x,
                              input logic [WIDTH-1:0] y, input logic c);
        int n;
        bus.mode = m;
        bus.a = x;
        bus.b = y;
        bus.cin = c;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 20) begin
            total++;
            bad++;
            $display("[TB] FAIL in_ready_timeout: in_ready=%0b required=1", bus.in_ready);
        end
        @(posedge clk);
        model_push(m, x, y, c);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++;
        if (obs !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got=%h required=0", obs);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready_after_reset: got=%b required=1", bus.in_ready);
        end
        acc_m = '0;
        cnt_m = 0;
        sb.delete();
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] sum_req;
        logic             ovf_req;
`ifdef PADD_SAT_EN
        sum_req = 8'd255;
        ovf_req = 1'b1;
`else
        sum_req = 8'd45;
        ovf_req = 1'b0;
`endif
        do_reset();
        bus.out_ready = 1'b1;
        drive_beat(2'd0, 8'd200, 8'd100, 1'b1);
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, sum_req, 1'b1, ovf_req}) begin
            bad++;
            $display("[TB] FAIL add_200_100: got sum=%0d cout=%b ovf=%b required sum=%0d cout=1 ovf=%b",
                     bus.sum, bus.cout, bus.ovf, sum_req, ovf_req);
        end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            drive_beat(2'd0, WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)));
            @(negedge clk);
            total++;
            e = sb.pop_front();
            if (obs !== {1'b1, e}) begin
                bad++;
                $display("[TB] FAIL add_random: got=%h required=%h", obs, {1'b1, e});
            end
        end
    endtask

    task automatic test_sub();
        do_reset();
        bus.out_ready = 1'b1;
        drive_beat(2'd1, 8'd5, 8'd7, 1'b1);
        @(negedge clk);
        total++;
`ifdef PADD_SAT_EN
        if ({bus.sum, bus.cout, bus.ovf} !== {8'd0, 1'b0, 1'b1}) begin
`else
        if ({bus.sum, bus.cout, bus.ovf} !== {8'd254, 1'b0, 1'b0}) begin
`endif
            bad++;
            $display("[TB] FAIL sub_5_7: got sum=%0d cout=%b ovf=%b", bus.sum, bus.cout, bus.ovf);
        end
        e = sb.pop_front();
        drive_beat(2'd1, 8'd7, 8'd5, 1'b0);
        @(negedge clk);
        total++;
        e = sb.pop_front();
        if (obs !== {1'b1, 8'd2, 1'b1, 1'b0, 1'b0} || obs !== {1'b1, e}) begin
            bad++;
            $display("[TB] FAIL sub_7_5: got=%h required=%h", obs, {1'b1, e});
        end
    endtask

    task automatic test_acc_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_beat(2'd2, 8'd10, WIDTH'($urandom_range(0, 255)), 1'b0);
            @(negedge clk);
            total++;
            e = sb.pop_front();
            if (bus.sum !== WIDTH'(10 * (i + 1)) || bus.epoch_wrap !== (i == 3) || obs !== {1'b1, e}) begin
                bad++;
                $display("[TB] FAIL acc_step%0d: got sum=%0d wrap=%b required sum=%0d wrap=%b",
                         i, bus.sum, bus.epoch_wrap, 10 * (i + 1), (i == 3));
            end
        end
        drive_beat(2'd2, 8'd1, 8'd0, 1'b0);
        @(negedge clk);
        total++;
        e = sb.pop_front();
        if (bus.sum !== 8'd1 || obs !== {1'b1, e}) begin
            bad++;
            $display("[TB] FAIL acc_after_wrap: got sum=%0d required=1", bus.sum);
        end
    endtask

    task automatic test_clr();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(2'd2, 8'd10, 8'd0, 1'b0);
            @(negedge clk);
            e = sb.pop_front();
        end
        drive_beat(2'd3, 8'd77, 8'd88, 1'b1);
        @(negedge clk);
        total++;
        e = sb.pop_front();
        if (bus.sum !== 8'd0 || bus.cout !== 1'b0 || obs !== {1'b1, e}) begin
            bad++;
            $display("[TB] FAIL clr_result: got=%h required=%h", obs, {1'b1, e});
        end
        drive_beat(2'd2, 8'd2, 8'd0, 1'b1);
        @(negedge clk);
        total++;
        e = sb.pop_front();
        if (bus.sum !== 8'd3 || obs !== {1'b1, e}) begin
            bad++;
            $display("[TB] FAIL acc_after_clr: got sum=%0d required=3", bus.sum);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        drive_beat(2'd0, 8'd1, 8'd2, 1'b0);
        bus.mode = 2'd0;
        bus.a = 8'd3;
        bus.b = 8'd4;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.sum !== 8'd3) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d: got ready=%b valid=%b sum=%0d required 0/1/3",
                         i, bus.in_ready, bus.out_valid, bus.sum);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        e = sb.pop_front();
        if (bus.in_ready !== 1'b1 || obs !== {1'b1, e}) begin
            bad++;
            $display("[TB] FAIL stall_release: got ready=%b obs=%h required 1/%h", bus.in_ready, obs, {1'b1, e});
        end
        @(posedge clk);
        model_push(2'd0, 8'd3, 8'd4, 1'b0);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        e = sb.pop_front();
        if (bus.sum !== 8'd7 || obs !== {1'b1, e}) begin
            bad++;
            $display("[TB] FAIL stall_second: got=%h required=%h", obs, {1'b1, e});
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_no_dup: got out_valid=%b required=0", bus.out_valid);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        bus.out_ready = 1'b0;
        drive_beat(2'd2, 8'd9, 8'd9, 1'b0);
        bus.mode = 2'd2;
        bus.a = 8'd50;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.in_valid = 1'b0;
        acc_m = '0;
        cnt_m = 0;
        sb.delete();
        @(negedge clk);
        total++;
        if (obs !== '0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_inflight: got obs=%h ready=%b required 0/1", obs, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        drive_beat(2'd2, 8'd3, 8'd0, 1'b0);
        @(negedge clk);
        total++;
        e = sb.pop_front();
        if (bus.sum !== 8'd3 || obs !== {1'b1, e}) begin
            bad++;
            $display("[TB] FAIL acc_after_rst: got sum=%0d required=3", bus.sum);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]       m;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             c;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            m = 2'($urandom_range(0, 3));
            x = WIDTH'($urandom_range(0, 255));
            y = WIDTH'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            bus.mode = m;
            bus.a = x;
            bus.b = y;
            bus.cin = c;
            bus.in_valid = (i < 8);
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL b2b_empty: scoreboard empty at beat %0d", i);
                end else begin
                    e = sb.pop_front();
                    if (obs !== {1'b1, e}) begin
                        bad++;
                        $display("[TB] FAIL b2b_beat%0d: got=%h required=%h", i - 1, obs, {1'b1, e});
                    end
                end
            end
            @(posedge clk);
            if (i < 8) model_push(m, x, y, c);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        acc_m = '0;
        cnt_m = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.mode = 2'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_acc_wrap();
        test_clr();
        test_backpressure();
        test_reset_inflight();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_parallel_adder_pipe.md
TT_UM_PARALLEL_ADDER_PIPE -- requirements
Module: tt_um_parallel_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 Parameter MAX_COUNT, default 1000, number of accepted operations per epoch before auto-clear (>=1).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 cin  input  1  carry-in.
REQ-010 mode  input  2  operation select: ADD=0, SUB=1, ACC=2, CLR=3.
REQ-011 out_valid  output  1  result register holds an unconsumed result.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out (ADD/ACC); NOT borrow (SUB).
REQ-015 ovf  output  1  result saturated (saturation build only; else 0).
REQ-016 epoch_wrap  output  1  one-cycle pulse when the epoch counter wraps.

Function
REQ-017 Accept = in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (one-deep output register, full throughput).
REQ-018 Latency SHALL be one cycle: result of a beat accepted at edge N visible at sum/cout with out_valid=1 after edge N.
REQ-019 sum/cout/ovf SHALL hold stable while out_valid && !out_ready.
REQ-020 out_valid SHALL clear on out_ready without simultaneous accept; simultaneous drain and accept SHALL load the new result with out_valid remaining 1.
REQ-021 ADD: {cout,sum} = a + b + cin, WIDTH+1-bit result.
REQ-022 SUB: {cout,sum} = a + ~b + 1 (cin ignored); cout=1 means no borrow.
REQ-023 ACC: {cout,sum} = acc + a + cin; internal acc register <= sum on accept (b ignored).
REQ-024 CLR: acc <= 0; result sum=0, cout=0, ovf=0.
REQ-025 Epoch counter SHALL increment on every accept; on the accept that brings it to MAX_COUNT it SHALL return to 0, clear acc (overriding ACC update), and pulse epoch_wrap for one cycle; that beat's result SHALL still be delivered unchanged.
REQ-026 Counter width SHALL be $clog2(MAX_COUNT+1); no count beyond MAX_COUNT is reachable.
REQ-027 No state (acc, counter, output) SHALL change without accept except out_valid drain.

Reset
REQ-028 On rst=1 at a clock edge: out_valid=0, sum=0, cout=0, ovf=0, epoch_wrap=0, acc=0, counter=0.
REQ-029 rst SHALL override any simultaneous accept or drain; an in-flight result is discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-031 Macro PADD_SAT_EN: when defined, ADD/ACC results with carry SHALL saturate sum to all-ones with ovf=1, SUB with borrow SHALL clamp sum to 0 with ovf=1; acc stores the saturated value; cout still reports raw carry.
REQ-032 Without PADD_SAT_EN: wrap-around arithmetic, ovf tied 0, no saturation logic synthesised.

Structure
REQ-033 Package padd_pkg SHALL hold the mode encoding (ADD, SUB, ACC, CLR) as typedef and constants.
REQ-034 Sub-module padd_ripple (parameter WIDTH, combinational ripple-carry chain of full adders: a, b, cin -> sum, cout) SHALL implement all arithmetic; single instance with muxed operands.

Verification (WIDTH=8, MAX_COUNT=4)
REQ-035 ADD a=200,b=100,cin=1, out_ready=1 -> next cycle sum=45, cout=1 (sat build: sum=255, ovf=1).
REQ-036 SUB a=5,b=7 -> sum=254, cout=0 (sat build: sum=0, ovf=1); SUB a=7,b=5 -> sum=2, cout=1.
REQ-037 ACC a=10 x3, cin=0 -> sums 10,20,30; 4th accept (epoch wrap) gives 40 with epoch_wrap=1, next ACC a=1 -> sum=1.
REQ-038 Backpressure: out_ready=0 after one accept -> in_ready=0, sum held; in_valid held 3 cycles, then out_ready=1 -> exactly one further accept, no loss/duplication.
REQ-039 rst=1 asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, sum=0, acc and counter 0 (next ACC a=3 -> sum=3).
REQ-040 CLR mid-accumulation (acc=30) -> sum=0; following ACC a=2,cin=1 -> sum=3.
